// File: rtl/pc_sequencer.sv
// Program counter sequencer: exception, stall, return, jump, branch and sequential fetch addressing.
// The return-address stack is built only when PC_SEQ_RAS_EN is defined.
module pc_sequencer #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(32'h80),
  parameter int unsigned       RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              exc,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_offset,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              call,
  input  logic              ret,
  output logic [ADDR_W-1:0] i_addr,
  output logic              i_valid,
  output logic              ras_ovf,
  output logic              ras_unf
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] pc_plus4, branch_pc, jump_pc;

  assign pc_plus4  = pc_q + ADDR_W'(4);
  assign branch_pc = pc_plus4 + (branch_offset << 2);
  assign jump_pc   = {jump_target[ADDR_W-1:2], 2'b00};

`ifdef PC_SEQ_RAS_EN
  localparam int unsigned PtrW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
  logic [ADDR_W-1:0] ras_d [RAS_DEPTH];
  logic [PtrW-1:0]   sp_q, sp_d, sp_inc;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic              ras_empty, ras_full;
  logic [ADDR_W-1:0] ras_top;
  logic              do_push, do_pop, ret_unf;

  // sp_q points at the newest entry; when full, sp_q + 1 is the oldest slot
  assign sp_inc    = sp_q + PtrW'(1);
  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == CntW'(RAS_DEPTH));
  assign ras_top   = ras_q[sp_q];
`endif

  always_comb begin
    pc_d    = pc_q;
    valid_d = 1'b1;
`ifdef PC_SEQ_RAS_EN
    do_push = 1'b0;
    do_pop  = 1'b0;
    ret_unf = 1'b0;
`endif
    if (!valid_q) begin
      // first edge out of reset only raises i_valid; PC stays at RESET_VEC
      pc_d = pc_q;
    end else if (exc) begin
      pc_d = EXC_VEC;
    end else if (stall) begin
      pc_d = pc_q;
    end else if (ret) begin
`ifdef PC_SEQ_RAS_EN
      if (ras_empty) begin
        pc_d    = pc_plus4;
        ret_unf = 1'b1;
      end else begin
        pc_d   = ras_top;
        do_pop = 1'b1;
      end
`else
      pc_d = pc_plus4;
`endif
    end else if (jump) begin
      pc_d = jump_pc;
`ifdef PC_SEQ_RAS_EN
      do_push = call;
`endif
    end else if (branch_taken) begin
      pc_d = branch_pc;
    end else begin
      pc_d = pc_plus4;
    end
  end

`ifdef PC_SEQ_RAS_EN
  always_comb begin
    ras_d = ras_q;
    sp_d  = sp_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unf_d = unf_q | ret_unf;
    if (do_push) begin
      ras_d[sp_inc] = pc_plus4;
      sp_d          = sp_inc;
      if (ras_full) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end else if (do_pop) begin
      sp_d  = sp_q - PtrW'(1);
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ras_q <= '{default: '0};
      sp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ras_q <= ras_d;
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign ras_ovf = ovf_q;
  assign ras_unf = unf_q;

  logic unused_bits;
  assign unused_bits = ^jump_target[1:0];
`else
  assign ras_ovf = 1'b0;
  assign ras_unf = 1'b0;

  // call and the stack depth have no effect without the return-address stack
  logic unused_bits;
  assign unused_bits = call ^ RAS_DEPTH[0] ^ (^jump_target[1:0]);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= RESET_VEC;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign i_addr  = pc_q;
  assign i_valid = valid_q;

endmodule
